store_narrow: RTL
=================

STORE_NARROW -- requirements
Module: store_narrow

Interface
REQ-001 Parameter: ADDR_W, default 32, width of the CPU byte address and the memory address.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  store request from the control unit; sampled only in IDLE.
REQ-005 addr  input  ADDR_W  byte address of the store.
REQ-006 wdata  input  32  register data to store; the value is right-justified.
REQ-007 size  input  2  store width: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 done  output  1  one-cycle pulse when the store has completed.
REQ-010 err  output  1  one-cycle pulse when a request is rejected (misaligned or illegal size).
REQ-011 mem_req  output  1  memory write request, held until acknowledged.
REQ-012 mem_addr  output  ADDR_W  word-aligned address: addr with bits [1:0] forced to 0.
REQ-013 mem_wdata  output  32  data with replicated lanes.
REQ-014 mem_be  output  4  byte enables; bit i covers mem_wdata[8i+7:8i].
REQ-015 mem_ack  input  1  memory accepts the write; valid only while mem_req=1.

Function
REQ-016 The FSM SHALL have four states: IDLE, REQ, DONE, ERR.
REQ-017 IDLE with start=1: addr, wdata and size SHALL be captured into internal registers at that edge.
REQ-018 IDLE with start=1 and a legal, aligned request: the next state SHALL be REQ.
REQ-019 IDLE with start=1 and an illegal request: the next state SHALL be ERR; no mem_req SHALL be issued.
REQ-020 Illegal request, any of:
  - size=11;
  - size=01 with addr[0]=1;
  - size=10 with addr[1:0]!=00.
  Byte stores SHALL never be misaligned.
REQ-021 REQ: mem_req=1, and mem_addr, mem_wdata and mem_be SHALL hold stable, driven from the captured registers.
REQ-022 REQ: the FSM SHALL stay in REQ until mem_ack=1 is sampled at an edge, then go to DONE; the wait is unbounded.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; start is ignored in DONE.
REQ-024 ERR: err=1 for exactly one cycle, then IDLE; mem_req SHALL stay 0.
REQ-025 Byte lanes (little-endian):
  - byte: mem_be = 0001 shifted left by addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - half: mem_be = 0011 if addr[1]=0, else 1100; mem_wdata = {2{wdata[15:0]}}.
  - word: mem_be = 1111; mem_wdata = wdata.
REQ-026 Outside REQ, mem_req=0, mem_be=0000, and mem_addr/mem_wdata SHALL hold their last values.
REQ-027 Minimum latency: start at edge N, mem_ack=1 at edge N+1, done high between edges N+1 and N+2.
REQ-028 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-029 mem_ack while mem_req=0 SHALL be ignored.
REQ-030 Changes on addr, wdata or size after capture SHALL NOT affect an in-flight store.
REQ-031 done and err SHALL never be high in the same cycle.

Reset
REQ-032 rst_n=0 SHALL force, immediately and independent of clk: state IDLE, busy=0, done=0, err=0, mem_req=0, mem_be=0000, mem_addr=0, mem_wdata=0.
REQ-033 Reset asserted in REQ SHALL abort the store; no done SHALL follow.
REQ-034 After reset deasserts, the first start SHALL be accepted normally.

Verification
REQ-035 Byte store: start, addr=0x1003, size=00, wdata=0x123456AB, ack 1 cycle later -> mem_addr=0x1000, mem_be=1000, mem_wdata=0xABABABAB; done one cycle after ack.
REQ-036 Half store: addr=0x2002, size=01, wdata=0xFFFF8001 -> mem_be=1100, mem_wdata=0x80018001; mem_req held for 5 cycles with ack=0, then ack -> done.
REQ-037 Misaligned half: addr=0x2001, size=01 -> err=1 for one cycle, mem_req never 1, busy=1 for one cycle.
REQ-038 Illegal size: size=11, any addr -> err pulse; a subsequent word store to addr=0x0, wdata=0xDEADBEEF -> mem_be=1111, mem_wdata=0xDEADBEEF.
REQ-039 start pulsed during REQ with a different addr -> ignored; only one done, mem_addr unchanged.
REQ-040 rst_n low for 1 cycle mid-REQ -> all outputs zero immediately, no done; the next store completes correctly.

Source files
------------

// File: rtl/store_narrow.sv
// store_narrow: narrow (byte/halfword/word) store unit.
// Takes a right-justified register value and a byte address, checks
// alignment, replicates the data across byte lanes, and issues a single
// word-aligned memory write with byte enables. It waits for the memory
// acknowledge and then pulses done. Rejected requests pulse err instead.
module store_narrow #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [1:0]        size,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ack
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        lane_be_q, lane_be_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              mem_req_q, mem_req_d;

   logic              req_legal;
   logic [3:0]        req_be;
   logic [31:0]       req_data;

   // Decode the incoming request: legality, byte enables and replicated lanes.
   always_comb begin
      req_legal = 1'b0;
      req_be    = 4'b0000;
      req_data  = 32'h0000_0000;
      case (size)
         2'b00: begin
            req_legal = 1'b1;
            req_be    = 4'b0001 << addr[1:0];
            req_data  = {4{wdata[7:0]}};
         end
         2'b01: begin
            req_legal = ~addr[0];
            req_be    = addr[1] ? 4'b1100 : 4'b0011;
            req_data  = {2{wdata[15:0]}};
         end
         2'b10: begin
            req_legal = (addr[1:0] == 2'b00);
            req_be    = 4'b1111;
            req_data  = wdata;
         end
         default: begin
            req_legal = 1'b0;
         end
      endcase
   end

   // Next state, capture of an accepted store, and next values of all outputs.
   always_comb begin
      state_d     = state_q;
      lane_be_d   = lane_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (req_legal) begin
                  state_d     = REQ;
                  lane_be_d   = req_be;
                  mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                  mem_wdata_d = req_data;
               end else begin
                  state_d = ERR;
               end
            end
         end
         REQ: begin
            if (mem_ack) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d    = (state_d != IDLE);
      done_d    = (state_d == DONE);
      err_d     = (state_d == ERR);
      mem_req_d = (state_d == REQ);
      mem_be_d  = (state_d == REQ) ? lane_be_d : 4'b0000;
   end

   // State and registered outputs; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lane_be_q   <= 4'b0000;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'h0000_0000;
         mem_be_q    <= 4'b0000;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         mem_req_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_be_q   <= lane_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         mem_req_q   <= mem_req_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;

endmodule
